// File: rtl/ysyx_22040632_if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, inst} with a misalignment tag.
// Define IFQ_BYPASS_EN to let an empty queue pass the fetch input straight to decode.
module ysyx_22040632_if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic                     out_misalign,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // The extra pointer MSB is the wrap bit separating full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = !full;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // Gated by rst so outputs collapse immediately while reset is held.
    assign bypass    = empty & in_valid & !flush & !rst;
    assign out_valid = (!empty & !flush) | bypass;
    assign out_pc    = bypass ? in_pc   : pc_mem[rd_ptr[AW-1:0]];
    assign out_inst  = bypass ? in_inst : inst_mem[rd_ptr[AW-1:0]];
    assign push      = in_valid & in_ready & !flush & !(bypass & out_ready);
`else
    assign out_valid = !empty & !flush;
    assign out_pc    = pc_mem[rd_ptr[AW-1:0]];
    assign out_inst  = inst_mem[rd_ptr[AW-1:0]];
    assign push      = in_valid & in_ready & !flush;
`endif

    assign pop          = out_valid & out_ready & !empty;
    assign out_misalign = |out_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
                inst_mem[wr_ptr[AW-1:0]] <= in_inst;
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_if_id_queue.sv
// Scoreboard bench for the fetch-to-decode queue: directed scenarios followed by random traffic.
// Expected contents are tracked as a plain queue of {pc, inst}; a monitor checks every cycle.
module tb_ysyx_22040632_if_id_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic [2:0]  count;

    int   vectors    = 0;
    int   miscompares = 0;
    ent_t sb[$];

    ysyx_22040632_if_id_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_misalign (out_misalign),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model is updated just after the clock edge.
    task automatic drive(input bit iv, input logic [63:0] pc, input logic [31:0] inst,
                         input bit ordy, input bit fl);
        bit acc;
        @(negedge clk);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = iv && !fl && (sb.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
        if (iv && !fl && sb.size() == 0 && ordy) acc = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        else if (acc) sb.push_back('{pc: pc, inst: inst});
    endtask

    task automatic idle_drain();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    endtask

    // Monitor: samples mid-cycle, after stimulus has settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                int   n;
                bit   exp_v;
                ent_t e;
                n     = sb.size();
                exp_v = (n > 0) && !flush;
`ifdef IFQ_BYPASS_EN
                if (n == 0 && in_valid && !flush) exp_v = 1'b1;
`endif
                chk("out_valid", 64'(out_valid), 64'(exp_v));
                chk("count", 64'(count), 64'(n));
                chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
                if (out_valid && out_ready) begin
                    if (n > 0) e = sb.pop_front();
                    else       e = '{pc: in_pc, inst: in_inst};
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", 64'(out_inst), 64'(e.inst));
                    chk("out_misalign", 64'(out_misalign), 64'(e.pc[1:0] != 2'b00));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", out_pc, 64'd0);
        #2 rst = 1'b0;

        // mid-stream reset with three entries held
        for (int i = 0; i < 3; i++) drive(1'b1, 64'h8000_0000 + 64'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_pc", out_pc, 64'd0);
        chk("mid_rst_out_inst", 64'(out_inst), 64'd0);
        chk("mid_rst_misalign", 64'(out_misalign), 64'd0);
        sb.delete();
        @(negedge clk);
        #3 rst = 1'b0;

        // fill, refuse a fifth entry, drain in order
        for (int i = 0; i < 4; i++) drive(1'b1, 64'h8000_0000 + 64'(4*i), 32'h2000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 64'h8000_0010, 32'h2004, 1'b0, 1'b0);
        drive(1'b1, 64'h8000_0010, 32'h2004, 1'b1, 1'b0);
        idle_drain();

        // steady push+pop at occupancy two
        for (int i = 0; i < 2; i++) drive(1'b1, 64'h8000_0040 + 64'(4*i), 32'h3000 + 32'(i), 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) drive(1'b1, 64'h8000_0040 + 64'(4*i), 32'h3000 + 32'(i), 1'b1, 1'b0);
        idle_drain();

        // flush with a same-cycle push that must vanish
        for (int i = 0; i < 3; i++) drive(1'b1, 64'h8000_0080 + 64'(4*i), 32'h4000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 64'h8000_0100, 32'h4444, 1'b0, 1'b1);
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_count", 64'(count), 64'd0);
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // misaligned pc after the pointers have wrapped
        drive(1'b1, 64'h8000_0002, 32'hdead_beef, 1'b0, 1'b0);
        idle_drain();

        // empty queue, offer and consume in the same cycle
        drive(1'b1, 64'h8000_0200, 32'h5555, 1'b1, 1'b0);
        idle_drain();

        for (int i = 0; i < 500; i++) begin
            logic [63:0] pc;
            pc = 64'h8000_0000 + 64'($urandom_range(0, 16'hffff));
            drive(($urandom % 4) != 0, pc, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        idle_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
